// File: rtl/map_scroll_pkg.sv
// Shared keycodes, direction/state enums and key helpers for the tile-stepped camera.
// Pure declarations; no logic or latency of its own.
package map_scroll_pkg;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_B = 8'h05;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    IDLE = 1'b0,
    MOVE = 1'b1
  } state_t;

  function automatic logic key_is_dir(input logic [7:0] k);
    return (k == KEY_W) || (k == KEY_S) || (k == KEY_A) || (k == KEY_D);
  endfunction

  function automatic dir_t key_to_dir(input logic [7:0] k);
    dir_t d;
    case (k)
      KEY_S:   d = DOWN;
      KEY_A:   d = LEFT;
      KEY_D:   d = RIGHT;
      default: d = UP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/scroll_key_decode.sv
// Combinational keycode -> {valid, direction, run}; the primary byte wins over the secondary.
// Zero latency; run (B key) is only honoured when SCROLL_RUN_EN is defined.
module scroll_key_decode
  import map_scroll_pkg::*;
(
  input  logic [15:0] keycode,
  output logic        req_vld,
  output dir_t        req_dir,
  output logic        req_run
);

  always_comb begin
    req_vld = 1'b0;
    req_dir = UP;
    if (key_is_dir(keycode[7:0])) begin
      req_vld = 1'b1;
      req_dir = key_to_dir(keycode[7:0]);
    end else if (key_is_dir(keycode[15:8])) begin
      req_vld = 1'b1;
      req_dir = key_to_dir(keycode[15:8]);
    end
  end

`ifdef SCROLL_RUN_EN
  assign req_run = (keycode[7:0] == KEY_B) || (keycode[15:8] == KEY_B);
`else
  assign req_run = 1'b0;
`endif

endmodule

// File: rtl/map_scroll_ctrl.sv
// Tile-stepped camera: WASD moves the scroll origin one whole tile, one step per frame_tick.
// Position updates on the tick edge; SCROLL_RUN_EN enables a 2-pixel step while B is held.
module map_scroll_ctrl
  import map_scroll_pkg::*;
#(
  parameter int MAP_W  = 480,
  parameter int MAP_H  = 320,
  parameter int VIEW_W = 240,
  parameter int VIEW_H = 160,
  parameter int TILE   = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic [15:0] keycode,
  output logic [9:0]  ScreenX,
  output logic [9:0]  ScreenY,
  output logic        moving,
  output logic [1:0]  dir,
  output logic        tile_done,
  output logic        blocked
);

  localparam logic [9:0] XMAX   = 10'(MAP_W - VIEW_W);
  localparam logic [9:0] YMAX   = 10'(MAP_H - VIEW_H);
  localparam logic [9:0] TILE_W = 10'(TILE);

  logic   req_vld, req_run;
  dir_t   req_dir;

  state_t     state_q, state_d;
  dir_t       dir_q, dir_d;
  logic [9:0] cnt_q, cnt_d;
  logic [1:0] step_q, step_d;
  logic [9:0] sx_q, sx_d, sy_q, sy_d;
  logic       tile_done_q, tile_done_d;
  logic       blocked_q, blocked_d;

  logic [1:0] new_step;
  dir_t       mv_dir;
  logic [9:0] mv_step, nx, ny, cnt_nx;

  scroll_key_decode u_key_decode (
    .keycode (keycode),
    .req_vld (req_vld),
    .req_dir (req_dir),
    .req_run (req_run)
  );

  function automatic logic at_edge(input dir_t d, input logic [9:0] x, input logic [9:0] y);
    logic r;
    case (d)
      UP:      r = (y == 10'd0);
      DOWN:    r = (y == YMAX);
      LEFT:    r = (x == 10'd0);
      default: r = (x == XMAX);
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    tile_done_d = 1'b0;
    blocked_d   = 1'b0;

    new_step = req_run ? 2'd2 : 2'd1;
    // IDLE steps with the freshly decoded request; MOVE keeps the latched one.
    mv_dir  = (state_q == IDLE) ? req_dir : dir_q;
    mv_step = {8'd0, (state_q == IDLE) ? new_step : step_q};
    cnt_nx  = cnt_q + mv_step;

    nx = sx_q;
    ny = sy_q;
    case (mv_dir)
      UP:      ny = sy_q - mv_step;
      DOWN:    ny = sy_q + mv_step;
      LEFT:    nx = sx_q - mv_step;
      default: nx = sx_q + mv_step;
    endcase

    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          if (req_vld) begin
            if (at_edge(req_dir, sx_q, sy_q)) begin
              blocked_d = 1'b1;
            end else begin
              state_d = MOVE;
              dir_d   = req_dir;
              step_d  = new_step;
              cnt_d   = mv_step;
              sx_d    = nx;
              sy_d    = ny;
            end
          end
        end
        default: begin
          sx_d  = nx;
          sy_d  = ny;
          cnt_d = cnt_nx;
          if (cnt_nx == TILE_W) begin
            tile_done_d = 1'b1;
            cnt_d       = 10'd0;
            // Chain straight into the next tile, judged from the tile-aligned position just reached.
            if (req_vld && !at_edge(req_dir, nx, ny)) begin
              dir_d  = req_dir;
              step_d = new_step;
            end else begin
              state_d = IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      dir_q       <= UP;
      cnt_q       <= 10'd0;
      step_q      <= 2'd1;
      sx_q        <= 10'd0;
      sy_q        <= 10'd0;
      tile_done_q <= 1'b0;
      blocked_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      tile_done_q <= tile_done_d;
      blocked_q   <= blocked_d;
    end
  end

  assign ScreenX   = sx_q;
  assign ScreenY   = sy_q;
  assign moving    = (state_q == MOVE);
  assign dir       = dir_q;
  assign tile_done = tile_done_q;
  assign blocked   = blocked_q;

endmodule

// File: tb/tb_map_scroll_ctrl.sv
// Bench for map_scroll_ctrl: directed scenarios then randomized key holds, all against
// a target-position model of the camera (a tile is a move toward a fixed destination).
module tb_map_scroll_ctrl;

  localparam int TILE = 16;
  localparam int XMAX = 240;
  localparam int YMAX = 160;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_tick;
  logic [15:0] keycode;
  logic [9:0]  ScreenX, ScreenY;
  logic        moving, tile_done, blocked;
  logic [1:0]  dir;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  int m_x, m_y, m_tx, m_ty, m_step, m_dir;
  bit m_mov, e_done, e_blk;

  map_scroll_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .keycode    (keycode),
    .ScreenX    (ScreenX),
    .ScreenY    (ScreenY),
    .moving     (moving),
    .dir        (dir),
    .tile_done  (tile_done),
    .blocked    (blocked)
  );

  always #5 Clk = ~Clk;

  function automatic bit byte_dir(input logic [7:0] b, output int d);
    d = 0;
    case (b)
      8'h1A: begin d = 0; return 1'b1; end
      8'h16: begin d = 1; return 1'b1; end
      8'h04: begin d = 2; return 1'b1; end
      8'h07: begin d = 3; return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  function automatic void decode(input logic [15:0] kc, output bit ok, output int d, output bit run);
    int d0, d1;
    bit v0, v1;
    v0 = byte_dir(kc[7:0], d0);
    v1 = byte_dir(kc[15:8], d1);
    ok = v0 || v1;
    d  = v0 ? d0 : d1;
`ifdef SCROLL_RUN_EN
    run = (kc[7:0] == 8'h05) || (kc[15:8] == 8'h05);
`else
    run = 1'b0;
`endif
  endfunction

  function automatic bit can_go(input int x, input int y, input int d);
    case (d)
      0:       return y > 0;
      1:       return y < YMAX;
      2:       return x > 0;
      default: return x < XMAX;
    endcase
  endfunction

  function automatic int dx(input int d);
    return (d == 2) ? -1 : (d == 3) ? 1 : 0;
  endfunction

  function automatic int dy(input int d);
    return (d == 0) ? -1 : (d == 1) ? 1 : 0;
  endfunction

  task automatic start_tile(input int d, input bit run);
    m_dir  = d;
    m_step = run ? 2 : 1;
    m_tx   = m_x + TILE * dx(d);
    m_ty   = m_y + TILE * dy(d);
  endtask

  task automatic model_tick();
    bit ok, run;
    int d;
    decode(keycode, ok, d, run);
    e_done = 1'b0;
    e_blk  = 1'b0;
    if (!m_mov) begin
      if (ok) begin
        if (can_go(m_x, m_y, d)) begin
          start_tile(d, run);
          m_x   = m_x + m_step * dx(d);
          m_y   = m_y + m_step * dy(d);
          m_mov = 1'b1;
        end else begin
          e_blk = 1'b1;
        end
      end
    end else begin
      m_x = m_x + m_step * dx(m_dir);
      m_y = m_y + m_step * dy(m_dir);
      if (m_x == m_tx && m_y == m_ty) begin
        e_done = 1'b1;
        if (ok && can_go(m_x, m_y, d)) start_tile(d, run);
        else m_mov = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_tx = 0; m_ty = 0; m_step = 1; m_dir = 0;
    m_mov = 1'b0; e_done = 1'b0; e_blk = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".x"},         32'(ScreenX),   32'(m_x));
    check({tag, ".y"},         32'(ScreenY),   32'(m_y));
    check({tag, ".moving"},    32'(moving),    32'(m_mov));
    check({tag, ".dir"},       32'(dir),       32'(m_dir));
    check({tag, ".tile_done"}, 32'(tile_done), 32'(e_done));
    check({tag, ".blocked"},   32'(blocked),   32'(e_blk));
  endtask

  task automatic tick(input string tag);
    @(negedge Clk);
    frame_tick = 1'b1;
    model_tick();
    @(posedge Clk);
    #1;
    frame_tick = 1'b0;
    check_all(tag);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
      e_done = 1'b0;
      e_blk  = 1'b0;
      check_all("gap");
    end
  endtask

  task automatic hold(input logic [15:0] kc, input int n);
    keycode = kc;
    repeat (n) tick("hold");
  endtask

  task automatic settle();
    keycode = 16'h0000;
    for (int i = 0; i < 100 && m_mov; i++) tick("settle");
    check("settle.idle", 32'(moving), 32'd0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 9))
      0: return 8'h1A;
      1: return 8'h16;
      2: return 8'h04;
      3: return 8'h07;
      4: return 8'h05;
      5: return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    frame_tick = 1'b0;
    keycode    = 16'h0000;
    Reset      = 1'b1;
    #2;
    do_reset();
    gap(2);

    // Hold D for 15 ticks, release before the 16th: tile still completes.
    keycode = 16'h0007;
    for (int i = 1; i <= 15; i++) begin
      tick("d_hold");
      check("d_hold.x_const", 32'(ScreenX), 32'(i));
      check("d_hold.moving_const", 32'(moving), 32'd1);
    end
    keycode = 16'h0000;
    tick("d_last");
    check("d_last.done_const", 32'(tile_done), 32'd1);
    check("d_last.x_const", 32'(ScreenX), 32'd16);
    check("d_last.idle_const", 32'(moving), 32'd0);
    gap(1);

    // Right edge: walk to 224, then one more tile to 240, then refused.
    do_reset();
    hold(16'h0007, 209);
    settle();
    check("edge.x224", 32'(ScreenX), 32'd224);
    hold(16'h0007, 16);
    check("edge.x240", 32'(ScreenX), 32'd240);
    check("edge.done", 32'(tile_done), 32'd1);
    tick("edge_blk");
    check("edge.blocked", 32'(blocked), 32'd1);
    check("edge.stay", 32'(ScreenX), 32'd240);
    check("edge.idle", 32'(moving), 32'd0);
    gap(1);

    // W at the top edge is refused.
    do_reset();
    keycode = 16'h001A;
    tick("top_blk");
    check("top.blocked", 32'(blocked), 32'd1);
    check("top.y", 32'(ScreenY), 32'd0);
    settle();

    // Primary byte (S) wins over secondary (A) from (32,32).
    do_reset();
    hold(16'h0007, 17);
    settle();
    hold(16'h0016, 17);
    settle();
    check("prio.x32", 32'(ScreenX), 32'd32);
    check("prio.y32", 32'(ScreenY), 32'd32);
    hold(16'h0416, 16);
    check("prio.y48", 32'(ScreenY), 32'd48);
    check("prio.xkeep", 32'(ScreenX), 32'd32);
    settle();

    // Tap D, then reset mid-tile: outputs clear at once, no tile_done afterwards.
    do_reset();
    keycode = 16'h0007;
    tick("tap");
    keycode = 16'h0000;
    repeat (3) tick("tap_run");
    check("tap.x4", 32'(ScreenX), 32'd4);
    check("tap.moving", 32'(moving), 32'd1);
    do_reset();
    check("rst.x", 32'(ScreenX), 32'd0);
    check("rst.moving", 32'(moving), 32'd0);
    repeat (16) tick("post_rst");

`ifdef SCROLL_RUN_EN
    do_reset();
    keycode = 16'h0507;
    for (int i = 1; i <= 8; i++) begin
      tick("run");
      check("run.x_const", 32'(ScreenX), 32'(2 * i));
    end
    check("run.done_const", 32'(tile_done), 32'd1);
    settle();
`endif

    // Randomized holds with irregular tick spacing.
    do_reset();
    repeat (150) begin
      int n;
      keycode = {pick_byte(), pick_byte()};
      n = $urandom_range(1, 80);
      repeat (n) begin
        tick("rand");
        if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
      end
    end
    settle();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/map_scroll_ctrl.md
# map_scroll_ctrl

Tile-stepped camera controller that sequences the scroll origin (ScreenX, ScreenY) consumed by the color mapper's map-ROM address generator. It converts held WASD keycodes into whole-tile camera moves: each move advances one pixel step per frame tick until a full tile is crossed. Moves are clamped so the 240x160 viewport never leaves the map. The color mapper takes ScreenX/ScreenY directly, replacing its free-running per-frame motion logic.

## Interface
- MAP_W, 480: map width in pixels
- MAP_H, 320: map height in pixels
- VIEW_W, 240: viewport width in map pixels
- VIEW_H, 160: viewport height in map pixels
- TILE, 16: tile size in pixels; must be a power of two and divide (MAP_W-VIEW_W) and (MAP_H-VIEW_H)

- Clk  in  1  the single clock; all state changes on posedge Clk
- Reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-Clk pulse per frame (vsync edge); all motion happens only on cycles where it is 1
- keycode  in  16  two USB HID key bytes: [7:0] primary, [15:8] secondary
- ScreenX  out  10  camera X origin in map pixels, 0..MAP_W-VIEW_W
- ScreenY  out  10  camera Y origin in map pixels, 0..MAP_H-VIEW_H
- moving  out  1  1 while state is MOVE
- dir  out  2  latched move direction: 0=up, 1=down, 2=left, 3=right
- tile_done  out  1  one-Clk pulse on the edge that completes a tile
- blocked  out  1  one-Clk pulse when a requested move is refused at a map edge

## Operation
- Key decode: W=8'h1A→up, S=8'h16→down, A=8'h04→left, D=8'h07→right. keycode[7:0] has priority; [15:8] is used only if [7:0] is not a direction. No direction decoded → no request.
- Limits: XMAX = MAP_W-VIEW_W (240), YMAX = MAP_H-VIEW_H (160).
- A request is blocked if up with ScreenY==0, down with ScreenY==YMAX, left with ScreenX==0, or right with ScreenX==XMAX.
- FSM states: IDLE, MOVE.
- IDLE, tick, valid unblocked request:
  - latch dir; set cnt=step; apply step to the axis on the same edge; go to MOVE.
- IDLE, tick, blocked request: pulse blocked; stay in IDLE.
- MOVE, tick: apply step; cnt += step.
  - When cnt reaches TILE, pulse tile_done.
  - On that same edge, if a valid unblocked request exists (evaluated against the post-step position), chain: latch the new dir, reset cnt, stay in MOVE. No idle frame is inserted between chained tiles.
  - Otherwise go to IDLE.
- Key release mid-tile does not abort; a tile always completes.
- Non-tick cycles: no state, position, or count change.
- In IDLE, ScreenX and ScreenY are always multiples of TILE.
- Arithmetic: 10-bit unsigned. Overflow is impossible by construction, because clamping is checked only at tile boundaries and the limits are tile-aligned.

## Timing
- Reset values: ScreenX=0, ScreenY=0, moving=0, dir=0, tile_done=0, blocked=0; state IDLE; cnt=0.
- Reset asserted mid-move returns to the reset values immediately (asynchronous).
- Position latency: ScreenX/ScreenY are registered and update on the tick edge; they are visible the cycle after frame_tick.
- A tile takes TILE/step ticks; the default is 16 ticks at step 1.
- tile_done and blocked are each high for exactly one Clk and never assert together.

## Configuration
- SCROLL_RUN_EN defined:
  - step=2 if either keycode byte equals 8'h05 (B) when a tile starts.
  - step is latched per tile, so a tile takes 8 ticks.
  - B does not count as a direction.
- SCROLL_RUN_EN undefined: step is fixed at 1; B is ignored.

## Structure
- Package map_scroll_pkg holds:
  - keycode constants (KEY_W, KEY_A, KEY_S, KEY_D, KEY_B)
  - dir_t enum (UP, DOWN, LEFT, RIGHT)
  - state_t enum (IDLE, MOVE)
- Sub-module scroll_key_decode: combinational keycode→{valid, dir_t, run} with the priority rule. It is instantiated once in map_scroll_ctrl.

## Test plan
- Reset, then hold D (keycode=16'h0007) for 16 ticks:
  - ScreenX steps 1..16, moving=1 throughout.
  - tile_done pulses on the 16th tick; the state returns to IDLE if D is released before that tick.
- Hold D continuously from (224,0):
  - reaches 240 after 16 ticks.
  - the next tick pulses blocked, ScreenX stays 240, moving=0.
- From (0,0), press W:
  - blocked pulses on the first tick; position unchanged.
- keycode=16'h0416 (A in [15:8], S in [7:0]) at (32,32):
  - S wins; ScreenY→48 after 16 ticks; ScreenX stays 32.
- Press D for one tick then release, and assert Reset at tick 5:
  - before Reset the move continues to completion (tap completes a tile).
  - on Reset, outputs are 0 immediately; no tile_done.
- With SCROLL_RUN_EN, keycode=16'h0507 from (0,0):
  - ScreenX=2,4,..,16; tile_done on the 8th tick.
